// File: rtl/dsp_bb_pkg.sv
// Shared helpers for the signed adder/comb building blocks: result-width rule
// and a constant-foldable ceil(log2) used to size pointers and counters.
package dsp_bb_pkg;

    // Full-precision width of a sum or difference of an A-bit and a B-bit operand.
    function automatic int out_width(input int a, input int b);
        return ((a > b) ? a : b) + 1;
    endfunction

    // ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/signed_comb_if.sv
// Sample-stream bundle of the signed comb stage. i_valid/o_valid are pure
// qualifiers: there is no ready, every valid beat is taken on the clock edge.
interface signed_comb_if #(
    parameter int IWIDTH = 16
);
    logic                     i_clear;
    logic                     i_valid;
    logic signed [IWIDTH-1:0] i_data;
    logic                     o_valid;
    logic signed [IWIDTH:0]   o_data;
    logic                     o_primed;

    modport master (
        output i_clear, i_valid, i_data,
        input  o_valid, o_data, o_primed
    );

    modport slave (
        input  i_clear, i_valid, i_data,
        output o_valid, o_data, o_primed
    );
endinterface

// File: rtl/sample_delay_line.sv
// DELAY-deep circular sample buffer: dout is the sample written DELAY writes
// ago (zero until that many writes have occurred since reset/clear).
module sample_delay_line
    import dsp_bb_pkg::*;
#(
    parameter int IWIDTH = 16,
    parameter int DELAY  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              we,
    input  logic [IWIDTH-1:0] din,
    output logic [IWIDTH-1:0] dout
);

    generate
        if (DELAY == 1) begin : g_single
            // A single entry: the pointer is implicitly constant 0.
            logic [IWIDTH-1:0] r;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r <= '0;
                end else if (clear) begin
                    r <= '0;
                end else if (we) begin
                    r <= din;
                end
            end

            assign dout = r;
        end else begin : g_ring
            localparam int PW = clog2(DELAY);

            logic [IWIDTH-1:0] mem [DELAY];
            logic [PW-1:0]     ptr;

            // The entry under the pointer is both the oldest sample and the
            // slot the incoming sample overwrites.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DELAY; i++) mem[i] <= '0;
                    ptr <= '0;
                end else if (clear) begin
                    for (int i = 0; i < DELAY; i++) mem[i] <= '0;
                    ptr <= '0;
                end else if (we) begin
                    mem[ptr] <= din;
                    ptr      <= (ptr == PW'(DELAY - 1)) ? '0 : ptr + PW'(1);
                end
            end

            assign dout = mem[ptr];
        end
    endgenerate

endmodule

// File: rtl/signed_comb.sv
// Pipelined signed comb y[n] = x[n] - x[n-DELAY] with one bit of growth,
// one-cycle latency, and a priming flag once DELAY samples have been taken.
module signed_comb
    import dsp_bb_pkg::*;
#(
    parameter int IWIDTH = 16,
    parameter int DELAY  = 1
) (
    input logic          i_clk,
    input logic          i_rst_n,
    signed_comb_if.slave bus
);

    localparam int OW = out_width(IWIDTH, IWIDTH);
    localparam int CW = clog2(DELAY + 1);

    logic              accept;
    logic [IWIDTH-1:0] oldest;
    logic [OW-1:0]     diff;
    logic [CW-1:0]     cnt;
    logic              valid_q;
    logic [OW-1:0]     data_q;

    // A sample arriving together with clear is dropped.
    assign accept = bus.i_valid & ~bus.i_clear;

    sample_delay_line #(
        .IWIDTH (IWIDTH),
        .DELAY  (DELAY)
    ) u_delay_line (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clear (bus.i_clear),
        .we    (accept),
        .din   (bus.i_data),
        .dout  (oldest)
    );

    assign diff = {bus.i_data[IWIDTH-1], bus.i_data} - {oldest[IWIDTH-1], oldest};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt     <= '0;
        end else begin
            valid_q <= accept;
            if (bus.i_clear) begin
                cnt <= '0;
            end else if (accept) begin
                data_q <= diff;
                if (cnt != CW'(DELAY)) cnt <= cnt + CW'(1);
            end
        end
    end

    assign bus.o_valid  = valid_q;
    assign bus.o_data   = data_q;
    assign bus.o_primed = (cnt == CW'(DELAY));

endmodule
